stage_fifo: RTL and testbench
=============================

// Module: stage_fifo
// PURPOSE
//  Clocked, parametrised inter-stage queue for the pipeline (fetch->decode, decode->execute, ...).
//  Replaces the event-driven stage queue with a single-clock valid/ready FIFO.
//  Adds any-depth storage, optional empty fall-through bypass, synchronous flush for
//  branch squash, occupancy count and almost-full flag.
// PARAMETERS
//  WIDTH         96          payload bits (instr, addr, PC+4)
//  DEPTH         16          entries; any integer >= 2, power of two not required
//  AFULL_THRESH  DEPTH-2     almost_full asserts when count >= this; legal 1..DEPTH
//  BYPASS        1           1: empty queue passes in_data to out_data same cycle; 0: min 1-cycle latency
// PORTS
//  CLK          in   1                     clock, rising edge
//  RESET        in   1                     asynchronous, active-high reset
//  flush        in   1                     synchronous clear of all entries (branch squash)
//  in_valid     in   1                     producer has data
//  in_data      in   WIDTH                 producer payload
//  in_ready     out  1                     FIFO can accept this cycle
//  out_valid    out  1                     data available to consumer
//  out_data     out  WIDTH                 head payload (or bypassed in_data)
//  out_ready    in   1                     consumer takes data this cycle
//  count        out  $clog2(DEPTH+1)       entries stored (excludes bypassed item)
//  almost_full  out  1                     count >= AFULL_THRESH
// BEHAVIOUR
//  - Push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated at the CLK edge.
//  - RESET high (async): head=tail=0, count=0; in_ready=0, out_valid=0, almost_full=0 while held.
//    Storage array is not reset. First cycle after release: in_ready=1.
//  - Reset asserted mid-operation discards all contents immediately; no partial transfer completes.
//  - in_ready = !RESET & !flush & (count != DEPTH). No combinational path from out_ready to in_ready.
//  - out_valid: BYPASS=0 -> (count != 0) & !flush. BYPASS=1 -> ((count != 0) | in_valid) & !flush.
//  - out_data = mem[head] when count != 0; = in_data when count==0 & BYPASS=1; else don't-care.
//  - Bypass: count==0, in_valid & out_ready -> item passes through, not written, count stays 0.
//    count==0, in_valid & !out_ready -> item written at tail, count -> 1.
//  - Occupancy states (derived from count): EMPTY (0), ACTIVE (1..DEPTH-1), FULL (DEPTH).
//    EMPTY->ACTIVE on stored push w/o pop; ACTIVE->FULL on push w/o pop at count DEPTH-1;
//    FULL->ACTIVE on pop; ACTIVE->EMPTY on pop w/o push at count 1; push+pop holds state.
//  - Simultaneous push+pop in ACTIVE: write tail, read head, count unchanged.
//  - FULL with pop requested: pop happens, push refused that cycle (in_ready=0), count -> DEPTH-1.
//  - Pointer wrap: head/tail in 0..DEPTH-1; value DEPTH-1 increments to 0 explicitly (no modulo
//    on power-of-two assumption). Count arithmetic is exact, never wraps.
//  - flush (sync, priority over push/pop): next edge head=tail=count=0; in_ready=0 and
//    out_valid=0 during the flush cycle, so no handshake completes; item presented is dropped.
//  - almost_full registered-derived from count only; never depends on same-cycle handshakes.
//  - Elaboration $error if DEPTH<2 or AFULL_THRESH outside 1..DEPTH.
// TESTING
//  1. Reset then 16 pushes of 0x1..0x10, out_ready=0, DEPTH=16 -> count 16, in_ready=0, almost_full
//     from count 14; then drain -> pops 0x1..0x10 in order, count 0, out_valid=0.
//  2. BYPASS=1, empty, in_valid=1 in_data=0xABC, out_ready=1 -> out_valid=1 out_data=0xABC same
//     cycle, count stays 0; BYPASS=0 same stimulus -> out_valid first seen next cycle.
//  3. DEPTH=5: 5 pushes, 3 pops, 3 pushes, drain -> order preserved across wrap, tail 4->0 seen.
//  4. Full (count=DEPTH), in_valid=1 & out_ready=1 one cycle -> one pop, no push, count=DEPTH-1.
//  5. count=7, flush=1 with in_valid=1 & out_ready=1 -> in_ready=0, out_valid=0 that cycle;
//     next cycle count=0, dropped item never appears at out_data.
//  6. count=4, RESET pulsed between edges -> count=0, out_valid=0 immediately (before next edge);
//     after release, next push 0x55 is first item popped.

Source files
------------

// File: rtl/stage_fifo_if.sv
// Valid/ready bundle between two pipeline stages, plus the queue's occupancy status.
// The producer/consumer side drives through master; the queue itself sits on slave.
interface stage_fifo_if #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             almost_full;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, almost_full
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, almost_full
    );
endinterface

// File: rtl/stage_fifo.sv
// Single-clock valid/ready inter-stage queue: any depth, optional empty fall-through,
// synchronous squash flush, occupancy count and almost-full flag.
module stage_fifo #(
    parameter int WIDTH        = 96,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = DEPTH - 2,
    parameter bit BYPASS       = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    stage_fifo_if.slave q_if
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    if (DEPTH < 2) begin : g_bad_depth
        $error("stage_fifo: DEPTH must be >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("stage_fifo: AFULL_THRESH must be within 1..DEPTH");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty, full, push, pop, wr, rd;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Only state and flush feed in_ready; out_ready never does.
    assign q_if.in_ready = !rst_i && !q_if.flush && !full;

    if (BYPASS) begin : g_bypass
        assign q_if.out_valid = !rst_i && !q_if.flush && (!empty || q_if.in_valid);
        assign q_if.out_data  = empty ? q_if.in_data : mem_q[head_q];
    end else begin : g_nobypass
        assign q_if.out_valid = !rst_i && !q_if.flush && !empty;
        assign q_if.out_data  = mem_q[head_q];
    end

    assign push = q_if.in_valid && q_if.in_ready;
    assign pop  = q_if.out_valid && q_if.out_ready;
    // A pop while empty can only be the fall-through item, which never touches storage.
    assign wr   = push && !(empty && pop);
    assign rd   = pop && !empty;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (q_if.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wr) tail_d = inc(tail_q);
            if (rd) head_d = inc(head_q);
            count_d = count_q + CW'(wr) - CW'(rd);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr) mem_q[tail_q] <= q_if.in_data;
    end

    assign q_if.count       = count_q;
    assign q_if.almost_full = (count_q >= CW'(AFULL_THRESH));
endmodule

// File: tb/tb_stage_fifo.sv
// Bench for stage_fifo: three configurations share one stimulus bus; a queue-based
// scoreboard supplies expected handshake, data, count and almost-full values.
module tb_stage_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [95:0] in_data = '0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    stage_fifo_if #(.WIDTH(96), .DEPTH(16)) if_a ();
    stage_fifo_if #(.WIDTH(96), .DEPTH(16)) if_b ();
    stage_fifo_if #(.WIDTH(96), .DEPTH(5))  if_c ();

    assign if_a.flush = flush; assign if_a.in_valid = in_valid;
    assign if_a.in_data = in_data; assign if_a.out_ready = out_ready;
    assign if_b.flush = flush; assign if_b.in_valid = in_valid;
    assign if_b.in_data = in_data; assign if_b.out_ready = out_ready;
    assign if_c.flush = flush; assign if_c.in_valid = in_valid;
    assign if_c.in_data = in_data; assign if_c.out_ready = out_ready;

    stage_fifo #(.WIDTH(96), .DEPTH(16), .AFULL_THRESH(14), .BYPASS(1'b1))
        u_a (.clk_i(clk), .rst_i(rst), .q_if(if_a.slave));
    stage_fifo #(.WIDTH(96), .DEPTH(16), .AFULL_THRESH(14), .BYPASS(1'b0))
        u_b (.clk_i(clk), .rst_i(rst), .q_if(if_b.slave));
    stage_fifo #(.WIDTH(96), .DEPTH(5), .AFULL_THRESH(3), .BYPASS(1'b1))
        u_c (.clk_i(clk), .rst_i(rst), .q_if(if_c.slave));

    int          sel = 0;
    logic        o_ir, o_ov, o_af;
    logic [95:0] o_od;
    logic [4:0]  o_cnt;

    always_comb begin
        o_ir = if_a.in_ready; o_ov = if_a.out_valid; o_od = if_a.out_data;
        o_cnt = if_a.count; o_af = if_a.almost_full;
        if (sel == 1) begin
            o_ir = if_b.in_ready; o_ov = if_b.out_valid; o_od = if_b.out_data;
            o_cnt = if_b.count; o_af = if_b.almost_full;
        end else if (sel == 2) begin
            o_ir = if_c.in_ready; o_ov = if_c.out_valid; o_od = if_c.out_data;
            o_cnt = 5'(if_c.count); o_af = if_c.almost_full;
        end
    end

    // Scoreboard model of the selected configuration.
    logic [95:0] sb[$];
    int          m_depth = 16;
    bit          m_byp = 1'b1;
    logic        e_ir, e_ov, e_af;
    logic [95:0] e_od;
    logic [4:0]  e_cnt;

    task automatic select(input int s);
        sel = s;
        m_depth = (s == 2) ? 5 : 16;
        m_byp = (s != 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle, record pre-edge expectations, then advance the model.
    task automatic step(input logic iv, input logic [95:0] d, input logic ordy, input logic fl);
        int n;
        bit pop, push;
        @(negedge clk);
        in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
        #1;
        n = sb.size();
        e_ir  = !fl && (n != m_depth);
        e_ov  = !fl && ((n != 0) || (m_byp && iv));
        e_od  = (n != 0) ? sb[0] : d;
        e_cnt = 5'(n);
        e_af  = (n >= m_depth - 2);
        pop  = e_ov && ordy;
        push = iv && e_ir;
        if (fl) sb.delete();
        else begin
            if (pop && n != 0) void'(sb.pop_front());
            if (push && !(pop && n == 0)) sb.push_back(d);
        end
    endtask

    task automatic test_reset();
        select(0);
        in_valid = 1'b1;
        @(negedge clk); #1;
        checks++; if (o_ir !== 1'b0) begin errors++; $display("FAIL rst_in_ready act=%b exp=0", o_ir); end
        checks++; if (o_ov !== 1'b0) begin errors++; $display("FAIL rst_out_valid act=%b exp=0", o_ov); end
        checks++; if (o_cnt !== 5'd0) begin errors++; $display("FAIL rst_count act=%0d exp=0", o_cnt); end
        checks++; if (o_af !== 1'b0) begin errors++; $display("FAIL rst_afull act=%b exp=0", o_af); end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (o_ir !== 1'b1) begin errors++; $display("FAIL rst_release_ready act=%b exp=1", o_ir); end
    endtask

    task automatic test_fill_drain();
        select(0); do_reset();
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 96'(i), 1'b0, 1'b0);
            checks++; if (o_ir !== e_ir) begin errors++; $display("FAIL fill_ready[%0d] act=%b exp=%b", i, o_ir, e_ir); end
            checks++; if (o_cnt !== e_cnt) begin errors++; $display("FAIL fill_count[%0d] act=%0d exp=%0d", i, o_cnt, e_cnt); end
            checks++; if (o_af !== e_af) begin errors++; $display("FAIL fill_afull[%0d] act=%b exp=%b", i, o_af, e_af); end
        end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (o_cnt !== 5'd16) begin errors++; $display("FAIL full_count act=%0d exp=16", o_cnt); end
        checks++; if (o_ir !== 1'b0) begin errors++; $display("FAIL full_ready act=%b exp=0", o_ir); end
        checks++; if (o_af !== 1'b1) begin errors++; $display("FAIL full_afull act=%b exp=1", o_af); end
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            checks++; if (o_ov !== e_ov) begin errors++; $display("FAIL drain_valid[%0d] act=%b exp=%b", i, o_ov, e_ov); end
            checks++; if (o_od !== e_od) begin errors++; $display("FAIL drain_data[%0d] act=%h exp=%h", i, o_od, e_od); end
            checks++; if (o_af !== e_af) begin errors++; $display("FAIL drain_afull[%0d] act=%b exp=%b", i, o_af, e_af); end
        end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (o_cnt !== 5'd0) begin errors++; $display("FAIL drained_count act=%0d exp=0", o_cnt); end
        checks++; if (o_ov !== 1'b0) begin errors++; $display("FAIL drained_valid act=%b exp=0", o_ov); end
    endtask

    task automatic test_bypass();
        select(0); do_reset();
        step(1'b1, 96'hABC, 1'b1, 1'b0);
        checks++; if (o_ov !== 1'b1) begin errors++; $display("FAIL byp_valid act=%b exp=1", o_ov); end
        checks++; if (o_od !== 96'hABC) begin errors++; $display("FAIL byp_data act=%h exp=abc", o_od); end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (o_cnt !== 5'd0) begin errors++; $display("FAIL byp_count act=%0d exp=0", o_cnt); end
        select(1); do_reset();
        step(1'b1, 96'hABC, 1'b1, 1'b0);
        checks++; if (o_ov !== 1'b0) begin errors++; $display("FAIL nobyp_valid0 act=%b exp=0", o_ov); end
        step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (o_ov !== 1'b1) begin errors++; $display("FAIL nobyp_valid1 act=%b exp=1", o_ov); end
        checks++; if (o_od !== e_od) begin errors++; $display("FAIL nobyp_data act=%h exp=%h", o_od, e_od); end
        checks++; if (o_cnt !== 5'd1) begin errors++; $display("FAIL nobyp_count act=%0d exp=1", o_cnt); end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (o_cnt !== 5'd0) begin errors++; $display("FAIL nobyp_after act=%0d exp=0", o_cnt); end
    endtask

    task automatic test_wrap();
        // 5 pushes, 3 pops, 3 pushes, then drain 5 -- tail wraps 4->0.
        logic       iv_t[16];
        logic       or_t[16];
        select(2); do_reset();
        for (int i = 0; i < 16; i++) begin
            iv_t[i] = (i < 5) || (i >= 8 && i < 11);
            or_t[i] = (i >= 5 && i < 8) || (i >= 11);
        end
        for (int i = 0; i < 16; i++) begin
            step(iv_t[i], 96'h100 + 96'(i), or_t[i], 1'b0);
            checks++; if (o_ir !== e_ir) begin errors++; $display("FAIL wrap_ready[%0d] act=%b exp=%b", i, o_ir, e_ir); end
            checks++; if (o_cnt !== e_cnt) begin errors++; $display("FAIL wrap_count[%0d] act=%0d exp=%0d", i, o_cnt, e_cnt); end
            checks++; if (o_af !== e_af) begin errors++; $display("FAIL wrap_afull[%0d] act=%b exp=%b", i, o_af, e_af); end
            if (or_t[i] && e_ov) begin
                checks++; if (o_od !== e_od) begin errors++; $display("FAIL wrap_data[%0d] act=%h exp=%h", i, o_od, e_od); end
            end
        end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (o_ov !== 1'b0) begin errors++; $display("FAIL wrap_empty act=%b exp=0", o_ov); end
    endtask

    task automatic test_full_pop();
        select(0); do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 96'h200 + 96'(i), 1'b0, 1'b0);
        step(1'b1, 96'hBAD, 1'b1, 1'b0);
        checks++; if (o_ir !== 1'b0) begin errors++; $display("FAIL fullpop_ready act=%b exp=0", o_ir); end
        checks++; if (o_od !== 96'h200) begin errors++; $display("FAIL fullpop_data act=%h exp=200", o_od); end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (o_cnt !== 5'd15) begin errors++; $display("FAIL fullpop_count act=%0d exp=15", o_cnt); end
        for (int i = 0; i < 15; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            checks++; if (o_od !== e_od) begin errors++; $display("FAIL fullpop_drain[%0d] act=%h exp=%h", i, o_od, e_od); end
        end
    endtask

    task automatic test_flush();
        select(0); do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 96'h300 + 96'(i), 1'b0, 1'b0);
        step(1'b1, 96'hDEAD, 1'b1, 1'b1);
        checks++; if (o_ir !== 1'b0) begin errors++; $display("FAIL flush_ready act=%b exp=0", o_ir); end
        checks++; if (o_ov !== 1'b0) begin errors++; $display("FAIL flush_valid act=%b exp=0", o_ov); end
        checks++; if (o_cnt !== 5'd7) begin errors++; $display("FAIL flush_count_pre act=%0d exp=7", o_cnt); end
        step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (o_cnt !== 5'd0) begin errors++; $display("FAIL flush_count act=%0d exp=0", o_cnt); end
        checks++; if (o_ov !== 1'b0) begin errors++; $display("FAIL flush_after_valid act=%b exp=0", o_ov); end
        step(1'b1, 96'h77, 1'b1, 1'b0);
        checks++; if (o_od !== 96'h77) begin errors++; $display("FAIL flush_next_data act=%h exp=77", o_od); end
    endtask

    task automatic test_async_reset();
        select(0); do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 96'h400 + 96'(i), 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b0; rst = 1'b1;
        #1;
        checks++; if (o_cnt !== 5'd0) begin errors++; $display("FAIL arst_count act=%0d exp=0", o_cnt); end
        checks++; if (o_ov !== 1'b0) begin errors++; $display("FAIL arst_valid act=%b exp=0", o_ov); end
        checks++; if (o_ir !== 1'b0) begin errors++; $display("FAIL arst_ready act=%b exp=0", o_ir); end
        #1;
        in_valid = 1'b0; rst = 1'b0;
        sb.delete();
        step(1'b1, 96'h55, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (o_od !== 96'h55) begin errors++; $display("FAIL arst_first_data act=%h exp=55", o_od); end
        checks++; if (o_cnt !== 5'd1) begin errors++; $display("FAIL arst_count1 act=%0d exp=1", o_cnt); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_bypass();
        test_wrap();
        test_full_pop();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
